ap_cpu_mem_narrow: RTL and testbench
====================================

# ap_cpu_mem_narrow

Bridges the CPU's 32-bit word port to a memory with a narrower data bus. Each CPU access is split into 32/MEM_DW sequential beats, for both reads and writes. Every beat uses its own ready handshake, so the block serves wait-stated SRAM, SDRAM controllers or on-chip RAM without change. It sits between the CPU data/instruction port and any 8- or 16-bit memory controller.

## Interface
- MEM_DW, 16: memory data width; legal values 8 or 16.
- BEATS, 32/MEM_DW: beats per CPU word; localparam derived from MEM_DW, not overridable.
- iCLK  in  1  clock; all state changes on the rising edge.
- iRESETn  in  1  reset; asynchronous, active-low.
- iCPU_EN  in  1  CPU request; held high until oCPU_RDY is seen.
- iCPU_RW  in  1  1 = write, 0 = read.
- oCPU_RDY  out  1  single-cycle completion pulse.
- iCPU_ADDR  in  32  word address.
- iCPU_WDATA  in  32  write data.
- oCPU_RDATA  out  32  read data; valid while oCPU_RDY is high and held afterwards.
- oMEM_EN  out  1  beat request.
- oMEM_RW  out  1  beat direction.
- oMEM_ADDR  out  32  beat address, in MEM_DW units.
- oMEM_WDATA  out  MEM_DW  beat write data.
- iMEM_RDATA  in  MEM_DW  beat read data; sampled when iMEM_RDY is high.
- iMEM_RDY  in  1  beat acknowledge.

## Operation
- States: IDLE, BEAT, DONE, RELEASE.
- IDLE -> BEAT when iCPU_EN = 1.
  - Latch iCPU_RW, iCPU_ADDR and iCPU_WDATA.
  - Set beat counter k = 0.
- BEAT:
  - oMEM_EN = 1 and oMEM_RW = latched RW.
  - oMEM_ADDR = latched ADDR * BEATS + k, truncated to 32 bits.
  - Beat order is big-endian. Beat k carries bits [31-k*MEM_DW -: MEM_DW].
  - Writes: oMEM_WDATA = that slice of the latched WDATA.
  - Reads: on iMEM_RDY = 1, the slice of the read-data register is loaded from iMEM_RDATA.
  - When iMEM_RDY = 1 and k < BEATS-1: k++ and stay in BEAT.
  - When iMEM_RDY = 1 and k = BEATS-1: go to DONE.
- DONE: oCPU_RDY = 1 for exactly one cycle and oMEM_EN = 0, then go to RELEASE.
- RELEASE: wait for iCPU_EN = 0, then go to IDLE. A held-high iCPU_EN never starts a second transaction.
- Abort: if iCPU_EN = 0 in BEAT, go to IDLE on the next edge.
  - No oCPU_RDY is produced.
  - Partial read data is discarded; oCPU_RDATA is unchanged.
  - A write may be left partially done in memory; this is accepted.
- Latched fields do not track input changes during a transaction.
- oCPU_RDATA updates only on entry to DONE. It loads from the internal assembly register.

## Timing
- Reset (asynchronous assert, synchronous-clean release) forces:
  - state = IDLE, k = 0.
  - oCPU_RDY = 0, oCPU_RDATA = 0.
  - oMEM_EN = 0, oMEM_RW = 0, oMEM_ADDR = 0, oMEM_WDATA = 0.
- Reset mid-transaction forces the same values immediately, without waiting for a clock edge.
- The mem-side outputs are registered or decoded from state and k only. There is no combinational path from CPU inputs to mem outputs.
- Latency with iMEM_RDY tied high:
  - EN sampled at edge 0.
  - Beats occupy cycles 1..BEATS.
  - oCPU_RDY is high in cycle BEATS+1.
  - MEM_DW = 16 gives RDY in cycle 3; MEM_DW = 8 gives RDY in cycle 5.
- Each low cycle of iMEM_RDY adds one cycle of latency.
- Minimum spacing between transactions: RELEASE must observe iCPU_EN = 0 for at least one cycle.
- Address wrap: iCPU_ADDR = 0x8000_0000 with MEM_DW = 16 gives beat addresses 0x0000_0000 and 0x0000_0001.

## Structure
- Shared package ap_cpu_mem_pkg holds:
  - the state encoding (IDLE = 0, BEAT = 1, DONE = 2, RELEASE = 3);
  - the function beats(mem_dw).
- No sub-module is needed. The beat slicer and assembler are a generate loop inside the module.
- The 16-bit instance replaces the existing 16-bit bridge wherever the memory provides a ready signal.

## Test plan
- MEM_DW = 16, read, ADDR 0x10, iMEM_RDY = 1:
  - beat addresses 0x20 then 0x21;
  - RDATA beats 0x1234 then 0x5678;
  - RDY in cycle 3 with oCPU_RDATA = 0x12345678.
- MEM_DW = 8, write 0xDEADBEEF to ADDR 3:
  - beats 0xDE@12, 0xAD@13, 0xBE@14, 0xEF@15, all with oMEM_RW = 1;
  - single RDY pulse.
- MEM_DW = 16, read, iMEM_RDY low for 3 cycles on each beat:
  - oMEM_ADDR holds during the wait;
  - RDY in cycle 9.
- iCPU_EN held high for 10 cycles after RDY:
  - exactly one transaction and one RDY pulse;
  - a new one starts only after EN drops and rises again.
- iCPU_EN dropped during beat 1 of an 8-bit read:
  - return to IDLE, no RDY, oCPU_RDATA keeps its previous value.
- iRESETn asserted mid-write with no clock edge:
  - all outputs go to 0 at once;
  - after release, a fresh read of 0xCAFEF00D completes correctly.

Source files
------------

// File: rtl/ap_cpu_mem_pkg.sv
// ap_cpu_mem_pkg: state encoding and beat-count helper shared by the narrow memory bridge.
package ap_cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BEAT    = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_e;

    function automatic int beats(input int mem_dw);
        return 32 / mem_dw;
    endfunction

endpackage

// File: rtl/ap_cpu_mem_narrow.sv
// ap_cpu_mem_narrow: splits each 32-bit CPU access into big-endian MEM_DW-wide beats,
// each beat waiting on its own memory ready.
module ap_cpu_mem_narrow
    import ap_cpu_mem_pkg::*;
#(
    parameter int MEM_DW = 16
) (
    input  logic              iCLK,
    input  logic              iRESETn,
    input  logic              iCPU_EN,
    input  logic              iCPU_RW,
    output logic              oCPU_RDY,
    input  logic [31:0]       iCPU_ADDR,
    input  logic [31:0]       iCPU_WDATA,
    output logic [31:0]       oCPU_RDATA,
    output logic              oMEM_EN,
    output logic              oMEM_RW,
    output logic [31:0]       oMEM_ADDR,
    output logic [MEM_DW-1:0] oMEM_WDATA,
    input  logic [MEM_DW-1:0] iMEM_RDATA,
    input  logic              iMEM_RDY
);

    localparam int BEATS = beats(MEM_DW);
    localparam int KW    = $clog2(BEATS);

    state_e            state_q;
    logic [KW-1:0]     k_q;
    logic              rw_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       asm_q;
    logic [31:0]       asm_d;
    logic [31:0]       rdata_q;
    logic [MEM_DW-1:0] wslice [BEATS];
    logic              beat_w;

    assign beat_w = state_q == BEAT;

    // Beat k maps to the k-th most significant slice of the word.
    for (genvar i = 0; i < BEATS; i++) begin : g_slice
        assign wslice[i] = wdata_q[31-i*MEM_DW -: MEM_DW];
        assign asm_d[31-i*MEM_DW -: MEM_DW] = (k_q == KW'(i) && !rw_q) ? iMEM_RDATA
                                                                      : asm_q[31-i*MEM_DW -: MEM_DW];
    end

    // Mem-side outputs depend only on registered state, never on CPU inputs.
    assign oMEM_EN    = beat_w;
    assign oMEM_RW    = beat_w & rw_q;
    assign oMEM_ADDR  = beat_w ? ((addr_q << KW) | 32'(k_q)) : '0;
    assign oMEM_WDATA = beat_w ? wslice[k_q] : '0;
    assign oCPU_RDY   = state_q == DONE;
    assign oCPU_RDATA = rdata_q;

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state_q <= IDLE;
            k_q     <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (iCPU_EN) begin
                    state_q <= BEAT;
                    rw_q    <= iCPU_RW;
                    addr_q  <= iCPU_ADDR;
                    wdata_q <= iCPU_WDATA;
                    k_q     <= '0;
                end
                BEAT: if (!iCPU_EN) begin
                    state_q <= IDLE;
                end else if (iMEM_RDY) begin
                    asm_q <= asm_d;
                    if (k_q == KW'(BEATS - 1)) begin
                        state_q <= DONE;
                        rdata_q <= asm_d;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DONE: state_q <= RELEASE;
                default: if (!iCPU_EN) state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ap_cpu_mem_narrow.sv
// tb_ap_cpu_mem_narrow: vector table plus hand sequences on 16- and 8-bit bridges, scoreboarded beats and read data.
module tb_ap_cpu_mem_narrow;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        en16, rw16, rdy16, men16, mrw16, mrdy16;
    logic [31:0] addr16, wdata16, rdata16, maddr16, word16;
    logic [15:0] mwd16, mrd16;
    logic        en8, rw8, rdy8, men8, mrw8, mrdy8;
    logic [31:0] addr8, wdata8, rdata8, maddr8, word8;
    logic [7:0]  mwd8, mrd8;

    // Bench memory: returns the big-endian slice of the current word selected by beat address.
    assign mrd16 = word16[31 - 16*int'(maddr16[0]) -: 16];
    assign mrd8  = word8[31 - 8*int'(maddr8[1:0]) -: 8];

    ap_cpu_mem_narrow #(.MEM_DW(16)) dut16 (
        .iCLK(clk), .iRESETn(rst_n), .iCPU_EN(en16), .iCPU_RW(rw16), .oCPU_RDY(rdy16),
        .iCPU_ADDR(addr16), .iCPU_WDATA(wdata16), .oCPU_RDATA(rdata16), .oMEM_EN(men16),
        .oMEM_RW(mrw16), .oMEM_ADDR(maddr16), .oMEM_WDATA(mwd16), .iMEM_RDATA(mrd16), .iMEM_RDY(mrdy16)
    );

    ap_cpu_mem_narrow #(.MEM_DW(8)) dut8 (
        .iCLK(clk), .iRESETn(rst_n), .iCPU_EN(en8), .iCPU_RW(rw8), .oCPU_RDY(rdy8),
        .iCPU_ADDR(addr8), .iCPU_WDATA(wdata8), .oCPU_RDATA(rdata8), .oMEM_EN(men8),
        .oMEM_RW(mrw8), .oMEM_ADDR(maddr8), .oMEM_WDATA(mwd8), .iMEM_RDATA(mrd8), .iMEM_RDY(mrdy8)
    );

    typedef struct { logic [31:0] addr; logic rw; logic [15:0] wd; } beat_t;
    typedef struct { logic chk; logic [31:0] v; } rexp_t;
    typedef struct { logic w8; logic rw; logic [31:0] addr; logic [31:0] wdata; logic [31:0] word; int stall; int lat; } vec_t;

    beat_t q16[$], q8[$];
    rexp_t r16[$], r8[$];
    rexp_t e16, e8;
    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (men16 && en16) begin
            if (q16.size() == 0) begin
                checks++; failures++;
                $display("FAIL beat16 unexpected: addr %h", maddr16);
            end else begin
                chk("beat16 addr", maddr16, q16[0].addr);
                chk("beat16 rw", 32'(mrw16), 32'(q16[0].rw));
                if (q16[0].rw) chk("beat16 wdata", 32'(mwd16), 32'(q16[0].wd));
                if (mrdy16) void'(q16.pop_front());
            end
        end
        if (rdy16) begin
            if (r16.size() == 0) begin
                checks++; failures++;
                $display("FAIL rdy16 unexpected: rdata %h", rdata16);
            end else begin
                e16 = r16.pop_front();
                if (e16.chk) chk("rdata16", rdata16, e16.v);
            end
        end
    end

    always @(negedge clk) if (rst_n) begin
        if (men8 && en8) begin
            if (q8.size() == 0) begin
                checks++; failures++;
                $display("FAIL beat8 unexpected: addr %h", maddr8);
            end else begin
                chk("beat8 addr", maddr8, q8[0].addr);
                chk("beat8 rw", 32'(mrw8), 32'(q8[0].rw));
                if (q8[0].rw) chk("beat8 wdata", 32'(mwd8), 32'(q8[0].wd));
                if (mrdy8) void'(q8.pop_front());
            end
        end
        if (rdy8) begin
            if (r8.size() == 0) begin
                checks++; failures++;
                $display("FAIL rdy8 unexpected: rdata %h", rdata8);
            end else begin
                e8 = r8.pop_front();
                if (e8.chk) chk("rdata8", rdata8, e8.v);
            end
        end
    end

    task automatic zero_chk(input string nm);
        chk({nm, " rdy16"}, 32'(rdy16), 0);
        chk({nm, " rdata16"}, rdata16, 0);
        chk({nm, " men16"}, 32'(men16), 0);
        chk({nm, " mrw16"}, 32'(mrw16), 0);
        chk({nm, " maddr16"}, maddr16, 0);
        chk({nm, " mwd16"}, 32'(mwd16), 0);
        chk({nm, " rdy8"}, 32'(rdy8), 0);
        chk({nm, " rdata8"}, rdata8, 0);
        chk({nm, " men8"}, 32'(men8), 0);
        chk({nm, " maddr8"}, maddr8, 0);
    endtask

    task automatic xact(input logic w8, input logic rw, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] word, input int stall, input int lat, input int hold, input string nm);
        int nb = w8 ? 4 : 2;
        int dw = w8 ? 8 : 16;
        int sc = 0;
        int cyc;
        bit got = 0;
        beat_t bt;
        for (int b = 0; b < nb; b++) begin
            bt.addr = a * nb + b;
            bt.rw   = rw;
            bt.wd   = 16'((wd >> (32 - (b + 1) * dw)) & ((1 << dw) - 1));
            if (w8) q8.push_back(bt); else q16.push_back(bt);
        end
        if (w8) begin
            r8.push_back('{chk: !rw, v: word});
            en8 = 1'b1; rw8 = rw; addr8 = a; wdata8 = wd; word8 = word;
        end else begin
            r16.push_back('{chk: !rw, v: word});
            en16 = 1'b1; rw16 = rw; addr16 = a; wdata16 = wd; word16 = word;
        end
        @(posedge clk); #1;
        for (cyc = 1; cyc <= 60; cyc++) begin
            if (w8) mrdy8 = men8 && sc == stall; else mrdy16 = men16 && sc == stall;
            @(negedge clk);
            if (w8 ? rdy8 : rdy16) begin got = 1; break; end
            if (w8 ? men8 : men16) sc = (w8 ? mrdy8 : mrdy16) ? 0 : sc + 1;
            @(posedge clk); #1;
        end
        chk({nm, " latency"}, got ? cyc : -1, lat);
        repeat (hold) begin
            @(negedge clk);
            chk({nm, " hold men"}, 32'(w8 ? men8 : men16), 0);
            chk({nm, " hold rdy"}, 32'(w8 ? rdy8 : rdy16), 0);
        end
        @(posedge clk); #1;
        en8 = 1'b0; en16 = 1'b0; mrdy8 = 1'b0; mrdy16 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t tv[7];
        tv[0] = '{w8: 1'b0, rw: 1'b0, addr: 32'h10,       wdata: 32'h0,        word: 32'h12345678, stall: 0, lat: 3};
        tv[1] = '{w8: 1'b1, rw: 1'b1, addr: 32'h3,        wdata: 32'hDEADBEEF, word: 32'h0,        stall: 0, lat: 5};
        tv[2] = '{w8: 1'b0, rw: 1'b0, addr: 32'h40,       wdata: 32'h0,        word: 32'h0BADF00D, stall: 3, lat: 9};
        tv[3] = '{w8: 1'b0, rw: 1'b0, addr: 32'h80000000, wdata: 32'h0,        word: 32'hA5A55A5A, stall: 0, lat: 3};
        tv[4] = '{w8: 1'b1, rw: 1'b0, addr: 32'h1000,     wdata: 32'h0,        word: 32'h89ABCDEF, stall: 0, lat: 5};
        tv[5] = '{w8: 1'b0, rw: 1'b1, addr: 32'h7,        wdata: 32'h13579BDF, word: 32'h0,        stall: 1, lat: 5};
        tv[6] = '{w8: 1'b1, rw: 1'b0, addr: 32'hFFFFFFFF, wdata: 32'h0,        word: 32'h01020304, stall: 0, lat: 5};
        {en16, rw16, mrdy16, en8, rw8, mrdy8} = '0;
        {addr16, wdata16, word16, addr8, wdata8, word8} = '0;
        #2 rst_n = 1'b0;
        #1 zero_chk("reset");
        repeat (2) @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++)
            xact(tv[i].w8, tv[i].rw, tv[i].addr, tv[i].wdata, tv[i].word, tv[i].stall, tv[i].lat, 0, $sformatf("vec%0d", i));
        xact(1'b0, 1'b0, 32'h44, 32'h0, 32'h600DCAFE, 0, 3, 10, "hold");
        xact(1'b0, 1'b0, 32'h45, 32'h0, 32'h0FEDCBA9, 0, 3, 0, "after_hold");
        q8.push_back('{addr: 32'h80, rw: 1'b0, wd: 16'h0});
        word8 = 32'hFFEEDDCC; en8 = 1'b1; rw8 = 1'b0; addr8 = 32'h20;
        @(posedge clk); #1 mrdy8 = 1'b1;
        @(posedge clk); #1;
        chk("abort in beat1 men8", 32'(men8), 1);
        en8 = 1'b0; mrdy8 = 1'b0;
        @(posedge clk); #1;
        chk("abort idle men8", 32'(men8), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort rdata8 kept", rdata8, 32'h01020304);
        chk("abort no rdy8", 32'(rdy8), 0);
        xact(1'b1, 1'b0, 32'h5, 32'h0, 32'h55AA33CC, 0, 5, 0, "after_abort");
        en16 = 1'b1; rw16 = 1'b1; addr16 = 32'h9; wdata16 = 32'h11223344;
        @(posedge clk); #1;
        chk("prewrite maddr16", maddr16, 32'h12);
        chk("prewrite mwd16", 32'(mwd16), 32'h1122);
        #1 rst_n = 1'b0;
        #1 zero_chk("midreset");
        en16 = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        xact(1'b0, 1'b0, 32'h33, 32'h0, 32'hCAFEF00D, 0, 3, 0, "fresh");
        chk("q16 drained", q16.size(), 0);
        chk("q8 drained", q8.size(), 0);
        chk("r16 drained", r16.size(), 0);
        chk("r8 drained", r8.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
